// File: rtl/alarm_scheduler_if.sv
// User write handshake between the UI (master) and the alarm scheduler (slave).
// The master holds wr_req, wr_slot and wr_data steady until it sees wr_ack.
interface alarm_scheduler_if;
    logic        wr_req;
    logic [2:0]  wr_slot;
    logic [12:0] wr_data;
    logic        wr_ack;

    modport master (output wr_req, output wr_slot, output wr_data, input wr_ack);
    modport slave  (input wr_req, input wr_slot, input wr_data, output wr_ack);
endinterface

// File: rtl/alarm_scheduler.sv
// Alarm scheduler: sole writer of the 7-slot alarm register bank. Arbitrates
// user writes against a per-minute scan, rings on the first armed slot that
// matches the current time, and handles snooze (reprograms slot 6) and dismiss.
module alarm_scheduler #(
    parameter int unsigned SNOOZE_MIN = 5
) (
    input  logic               Clock,
    input  logic               Clear,
    input  logic               tick,
    input  logic [10:0]        cur_time,
    alarm_scheduler_if.slave   wr,
    input  logic [12:0]        Q_r0,
    input  logic [12:0]        Q_r1,
    input  logic [12:0]        Q_r2,
    input  logic [12:0]        Q_r3,
    input  logic [12:0]        Q_r4,
    input  logic [12:0]        Q_r5,
    input  logic [12:0]        Q_r6,
    output logic [2:0]         STO,
    output logic [12:0]        D,
    output logic               Enable,
    input  logic               dismiss,
    input  logic               snooze,
    output logic               alarm,
    output logic [2:0]         alarm_slot,
    output logic               busy
);

    typedef enum logic [2:0] {
        IDLE, WRITE, SCAN, RING, SNZ_WR, DIS_WR
    } state_t;

    localparam logic [2:0] SNOOZE_SLOT = 3'd6;

    state_t      state, next_state;
    logic        tick_pend;
    logic [2:0]  idx;
    logic [10:0] snap;

    // Slot view indexed by the scan pointer; entry 7 is a never-matching filler.
    logic [12:0] slot_q [8];
    logic [12:0] cur_q;
    logic        scan_hit;
    logic        scan_entry;

    assign slot_q[0] = Q_r0;
    assign slot_q[1] = Q_r1;
    assign slot_q[2] = Q_r2;
    assign slot_q[3] = Q_r3;
    assign slot_q[4] = Q_r4;
    assign slot_q[5] = Q_r5;
    assign slot_q[6] = Q_r6;
    assign slot_q[7] = 13'd0;

    assign cur_q      = slot_q[idx];
    // Armed bit must be set; reserved bit 11 is masked out of the compare.
    assign scan_hit   = (state == SCAN) && ((cur_q & 13'h17FF) == {2'b10, snap});
    assign scan_entry = (state != SCAN) && (next_state == SCAN);

    // Snooze target: snapped time plus SNOOZE_MIN with minute and hour wrap.
    logic [6:0]  snz_min_sum;
    logic [5:0]  snz_min;
    logic [4:0]  snz_hour_inc;
    logic [4:0]  snz_hour;

    assign snz_min_sum  = {1'b0, snap[5:0]} + 7'(SNOOZE_MIN);
    assign snz_hour_inc = snap[10:6] + 5'd1;

    // Fold minute overflow into the hour and wrap 24:xx to 00:xx.
    always_comb begin
        snz_min  = snz_min_sum[5:0];
        snz_hour = snap[10:6];
        if (snz_min_sum >= 7'd60) begin
            snz_min  = 6'(snz_min_sum - 7'd60);
            snz_hour = (snz_hour_inc == 5'd24) ? 5'd0 : snz_hour_inc;
        end
    end

    // State register plus scan bookkeeping (pending tick, pointer, time snapshot).
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state      <= IDLE;
            tick_pend  <= 1'b0;
            idx        <= 3'd0;
            snap       <= 11'd0;
            alarm_slot <= 3'd0;
        end else begin
            state <= next_state;
            // A fresh tick always wins so a minute arriving on scan entry is not lost.
            if (tick)
                tick_pend <= 1'b1;
            else if (scan_entry)
                tick_pend <= 1'b0;
            idx <= (state == SCAN && next_state == SCAN) ? idx + 3'd1 : 3'd0;
            if (scan_entry)
                snap <= cur_time;
            if (scan_hit)
                alarm_slot <= idx;
        end
    end

    // Next-state decode; a tick in flight blocks a new write so SCAN goes first.
    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            IDLE: begin
                if (tick_pend)
                    next_state = SCAN;
                else if (wr.wr_req && !tick)
                    next_state = WRITE;
            end
            WRITE:  next_state = IDLE;
            SCAN: begin
                if (scan_hit)
                    next_state = RING;
                else if (idx == 3'd6)
                    next_state = IDLE;
            end
            RING: begin
                if (dismiss)
                    next_state = (alarm_slot == SNOOZE_SLOT) ? DIS_WR : IDLE;
                else if (snooze)
                    next_state = SNZ_WR;
            end
            SNZ_WR: next_state = IDLE;
            DIS_WR: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    logic [2:0]  sto_d;
    logic [12:0] d_d;
    logic        enable_d;
    logic        ack_d;
    logic        alarm_d;
    logic        busy_d;

    always_comb begin
        sto_d    = 3'd0;
        d_d      = 13'd0;
        enable_d = 1'b0;
        ack_d    = 1'b0;
        alarm_d  = 1'b0;
        busy_d   = 1'b0;
        case (next_state)
            WRITE: begin
                ack_d  = 1'b1;
                busy_d = 1'b1;
                if (wr.wr_slot != 3'd7) begin
                    enable_d = 1'b1;
                    sto_d    = wr.wr_slot;
                    d_d      = wr.wr_data;
                end
            end
            SCAN:   busy_d = 1'b1;
            RING:   alarm_d = 1'b1;
            SNZ_WR: begin
                busy_d   = 1'b1;
                enable_d = 1'b1;
                sto_d    = SNOOZE_SLOT;
                d_d      = {1'b1, 1'b0, snz_hour, snz_min};
            end
            DIS_WR: begin
                busy_d   = 1'b1;
                enable_d = 1'b1;
                sto_d    = SNOOZE_SLOT;
            end
            default: ;
        endcase
    end

    // Registered outputs; Clear forces them all low immediately.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            STO       <= 3'd0;
            D         <= 13'd0;
            Enable    <= 1'b0;
            wr.wr_ack <= 1'b0;
            alarm     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            STO       <= sto_d;
            D         <= d_d;
            Enable    <= enable_d;
            wr.wr_ack <= ack_d;
            alarm     <= alarm_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Self-checking bench for alarm_scheduler: a behavioural register bank, a
// scoreboard of expected bank writes, and one task per scenario.
module tb_alarm_scheduler;

    logic        Clock = 1'b0;
    logic        Clear;
    logic        tick;
    logic [10:0] cur_time;
    logic        dismiss;
    logic        snooze;
    logic [2:0]  STO;
    logic [12:0] D;
    logic        Enable;
    logic        alarm;
    logic [2:0]  alarm_slot;
    logic        busy;

    logic [12:0] bank [7] = '{default: 13'd0};

    alarm_scheduler_if wr_if();

    typedef struct packed {
        logic [2:0]  slot;
        logic [12:0] data;
    } bank_wr_t;

    bank_wr_t exp_q[$];
    bank_wr_t obs_q[$];
    int zero_viol = 0;
    int checks    = 0;
    int failures  = 0;

    alarm_scheduler #(.SNOOZE_MIN(5)) dut (
        .Clock      (Clock),
        .Clear      (Clear),
        .tick       (tick),
        .cur_time   (cur_time),
        .wr         (wr_if.slave),
        .Q_r0       (bank[0]),
        .Q_r1       (bank[1]),
        .Q_r2       (bank[2]),
        .Q_r3       (bank[3]),
        .Q_r4       (bank[4]),
        .Q_r5       (bank[5]),
        .Q_r6       (bank[6]),
        .STO        (STO),
        .D          (D),
        .Enable     (Enable),
        .dismiss    (dismiss),
        .snooze     (snooze),
        .alarm      (alarm),
        .alarm_slot (alarm_slot),
        .busy       (busy)
    );

    always #5 Clock = ~Clock;

    // Register bank model: samples the write port on the rising edge.
    always @(posedge Clock) begin
        if (Enable && STO < 3'd7)
            bank[STO] <= D;
    end

    // Monitor: record every bank write, count idle cycles with non-zero STO/D.
    always @(negedge Clock) begin
        bank_wr_t w;
        if (Enable) begin
            w.slot = STO;
            w.data = D;
            obs_q.push_back(w);
        end else if (STO != 3'd0 || D != 13'd0) begin
            zero_viol++;
        end
    end

    function automatic logic [12:0] mk(input logic armed, input int h, input int m);
        return {armed, 1'b0, 5'(h), 6'(m)};
    endfunction

    task automatic push_exp(input logic [2:0] slot, input logic [12:0] data);
        bank_wr_t w;
        w.slot = slot;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Tick pulse sampled on the next edge; returns just after that edge.
    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] slot, input logic [12:0] data);
        bit acked = 0;
        wr_if.wr_slot = slot;
        wr_if.wr_data = data;
        wr_if.wr_req  = 1'b1;
        if (slot != 3'd7)
            push_exp(slot, data);
        for (int i = 0; i < 40 && !acked; i++) begin
            step();
            if (wr_if.wr_ack === 1'b1)
                acked = 1;
        end
        wr_if.wr_req = 1'b0;
        checks++;
        if (!acked) begin
            failures++;
            $display("FAIL do_write_ack slot=%0d: wr_ack never seen, required within 40 cycles", slot);
        end
        step();
    endtask

    // Called just after the tick edge n: alarm must stay low to n+1+k, high from n+2+k.
    task automatic expect_ring(input string name, input int k);
        repeat (k + 1) step();
        checks++;
        if ({alarm, busy} !== 2'b01) begin
            failures++;
            $display("FAIL %s_pre_ring: alarm,busy=%b required 01", name, {alarm, busy});
        end
        step();
        checks++;
        if ({alarm, alarm_slot, busy} !== {1'b1, 3'(k), 1'b0}) begin
            failures++;
            $display("FAIL %s_ring: alarm=%b slot=%0d busy=%b required alarm=1 slot=%0d busy=0",
                     name, alarm, alarm_slot, busy, k);
        end
    endtask

    task automatic test_reset();
        Clear = 1'b1;
        tick = 1'b0; dismiss = 1'b0; snooze = 1'b0; cur_time = 11'd0;
        wr_if.wr_req = 1'b0; wr_if.wr_slot = 3'd0; wr_if.wr_data = 13'd0;
        repeat (3) @(posedge Clock);
        #1;
        checks++;
        if ({STO, D, Enable, wr_if.wr_ack, alarm, alarm_slot, busy} !== 23'd0) begin
            failures++;
            $display("FAIL reset_outputs: STO=%0d D=%h En=%b ack=%b alarm=%b slot=%0d busy=%b required all 0",
                     STO, D, Enable, wr_if.wr_ack, alarm, alarm_slot, busy);
        end
        Clear = 1'b0;
        step(); step();
        checks++;
        if ({Enable, busy, alarm} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle: En,busy,alarm=%b required 000", {Enable, busy, alarm});
        end
    endtask

    task automatic test_write();
        logic [12:0] w = mk(1, 7, 30);
        wr_if.wr_slot = 3'd2;
        wr_if.wr_data = w;
        wr_if.wr_req  = 1'b1;
        push_exp(3'd2, w);
        step();
        checks++;
        if ({wr_if.wr_ack, Enable, STO, D, busy} !== {1'b1, 1'b1, 3'd2, w, 1'b1}) begin
            failures++;
            $display("FAIL write_cycle: ack=%b En=%b STO=%0d D=%h busy=%b required 1 1 2 %h 1",
                     wr_if.wr_ack, Enable, STO, D, busy, w);
        end
        wr_if.wr_req = 1'b0;
        step();
        checks++;
        if ({wr_if.wr_ack, Enable, STO, D, busy} !== 19'd0) begin
            failures++;
            $display("FAIL write_after: ack=%b En=%b STO=%0d D=%h busy=%b required all 0",
                     wr_if.wr_ack, Enable, STO, D, busy);
        end
        // Invalid slot: acknowledged, nothing written.
        wr_if.wr_slot = 3'd7;
        wr_if.wr_data = mk(1, 1, 1);
        wr_if.wr_req  = 1'b1;
        step();
        checks++;
        if ({wr_if.wr_ack, Enable} !== 2'b10) begin
            failures++;
            $display("FAIL write_slot7: ack,En=%b required 10", {wr_if.wr_ack, Enable});
        end
        wr_if.wr_req = 1'b0;
        step();
    endtask

    task automatic test_ring_snooze();
        cur_time = {5'd7, 6'd30};
        pulse_tick();
        expect_ring("ring_slot2", 2);
        snooze = 1'b1;
        push_exp(3'd6, mk(1, 7, 35));
        step();
        snooze = 1'b0;
        checks++;
        if ({Enable, STO, D, alarm, busy} !== {1'b1, 3'd6, mk(1, 7, 35), 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL snooze_0730: En=%b STO=%0d D=%h alarm=%b busy=%b required 1 6 %h 0 1",
                     Enable, STO, D, alarm, busy, mk(1, 7, 35));
        end
        step();
        checks++;
        if ({Enable, busy} !== 2'b00) begin
            failures++;
            $display("FAIL snooze_done: En,busy=%b required 00", {Enable, busy});
        end
    endtask

    task automatic test_priority();
        do_write(3'd1, mk(1, 7, 30));
        do_write(3'd4, mk(1, 7, 30) | 13'h0800);
        cur_time = {5'd7, 6'd30};
        pulse_tick();
        expect_ring("prio_slot1", 1);
        dismiss = 1'b1;
        step();
        dismiss = 1'b0;
        checks++;
        if ({alarm, Enable, busy} !== 3'b000) begin
            failures++;
            $display("FAIL dismiss_slot1: alarm,En,busy=%b required 000", {alarm, Enable, busy});
        end
        do_write(3'd1, mk(0, 7, 30));
        do_write(3'd2, 13'd0);
        pulse_tick();
        expect_ring("disarm_slot4", 4);
        dismiss = 1'b1;
        step();
        dismiss = 1'b0;
        do_write(3'd4, mk(0, 7, 30));
        pulse_tick();
        repeat (7) step();
        checks++;
        if ({busy, alarm} !== 2'b10) begin
            failures++;
            $display("FAIL nomatch_scan: busy,alarm=%b required 10", {busy, alarm});
        end
        step();
        checks++;
        if ({busy, alarm} !== 2'b00) begin
            failures++;
            $display("FAIL nomatch_idle: busy,alarm=%b required 00", {busy, alarm});
        end
    endtask

    task automatic test_snooze_wrap();
        do_write(3'd3, mk(1, 23, 58));
        cur_time = {5'd23, 6'd58};
        pulse_tick();
        expect_ring("ring_2358", 3);
        snooze = 1'b1;
        push_exp(3'd6, mk(1, 0, 3));
        step();
        snooze = 1'b0;
        checks++;
        if ({Enable, STO, D} !== {1'b1, 3'd6, mk(1, 0, 3)}) begin
            failures++;
            $display("FAIL snooze_wrap: En=%b STO=%0d D=%h required 1 6 %h", Enable, STO, D, mk(1, 0, 3));
        end
        step();
        cur_time = {5'd0, 6'd3};
        pulse_tick();
        expect_ring("ring_slot6", 6);
        dismiss = 1'b1;
        push_exp(3'd6, 13'd0);
        step();
        dismiss = 1'b0;
        checks++;
        if ({Enable, STO, D, alarm, busy} !== {1'b1, 3'd6, 13'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL dismiss_slot6: En=%b STO=%0d D=%h alarm=%b busy=%b required 1 6 0 0 1",
                     Enable, STO, D, alarm, busy);
        end
        step();
        cur_time = {5'd23, 6'd58};
        pulse_tick();
        expect_ring("ring_both", 3);
        dismiss = 1'b1;
        snooze  = 1'b1;
        step();
        dismiss = 1'b0;
        snooze  = 1'b0;
        checks++;
        if ({Enable, alarm, busy} !== 3'b000) begin
            failures++;
            $display("FAIL dismiss_wins: En,alarm,busy=%b required 000", {Enable, alarm, busy});
        end
        step();
    endtask

    task automatic test_arbitration();
        int  ack_cycle = -1;
        bit  scan_first;
        bit  ring_acked = 0;
        cur_time = {5'd12, 6'd0};
        wr_if.wr_slot = 3'd5;
        wr_if.wr_data = mk(1, 12, 1);
        wr_if.wr_req  = 1'b1;
        push_exp(3'd5, mk(1, 12, 1));
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        scan_first = (busy === 1'b1) && (wr_if.wr_ack === 1'b0);
        checks++;
        if (!scan_first) begin
            failures++;
            $display("FAIL tick_vs_wr: busy=%b ack=%b required busy=1 ack=0", busy, wr_if.wr_ack);
        end
        for (int c = 2; c <= 20 && ack_cycle < 0; c++) begin
            step();
            if (wr_if.wr_ack === 1'b1) begin
                ack_cycle = c;
                wr_if.wr_req = 1'b0;
            end
        end
        wr_if.wr_req = 1'b0;
        checks++;
        if (ack_cycle != 9) begin
            failures++;
            $display("FAIL wr_during_scan: ack at cycle %0d required 9", ack_cycle);
        end
        step();
        cur_time = {5'd12, 6'd1};
        pulse_tick();
        expect_ring("ring_slot5", 5);
        wr_if.wr_slot = 3'd0;
        wr_if.wr_data = 13'd0;
        wr_if.wr_req  = 1'b1;
        push_exp(3'd0, 13'd0);
        repeat (3) begin
            step();
            if (wr_if.wr_ack === 1'b1)
                ring_acked = 1;
        end
        dismiss = 1'b1;
        step();
        dismiss = 1'b0;
        if (wr_if.wr_ack === 1'b1)
            ring_acked = 1;
        checks++;
        if (ring_acked) begin
            failures++;
            $display("FAIL wr_during_ring: wr_ack=1 while ringing required 0");
        end
        step();
        checks++;
        if (wr_if.wr_ack !== 1'b1) begin
            failures++;
            $display("FAIL wr_after_ring: wr_ack=%b required 1", wr_if.wr_ack);
        end
        wr_if.wr_req = 1'b0;
        step();
    endtask

    task automatic test_clear_mid_scan();
        bit activity = 0;
        cur_time = {5'd12, 6'd1};
        pulse_tick();
        step();
        step();
        #2;
        Clear = 1'b1;
        #1;
        checks++;
        if ({STO, D, Enable, wr_if.wr_ack, alarm, alarm_slot, busy} !== 23'd0) begin
            failures++;
            $display("FAIL clear_async: STO=%0d D=%h En=%b ack=%b alarm=%b slot=%0d busy=%b required all 0",
                     STO, D, Enable, wr_if.wr_ack, alarm, alarm_slot, busy);
        end
        step();
        step();
        Clear = 1'b0;
        repeat (10) begin
            step();
            if (Enable || alarm || busy)
                activity = 1;
        end
        checks++;
        if (activity) begin
            failures++;
            $display("FAIL clear_no_late: activity after Clear, required none");
        end
    endtask

    task automatic test_bank_writes();
        int n = (exp_q.size() < obs_q.size()) ? exp_q.size() : obs_q.size();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL bank_write_count: observed %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL bank_write_%0d: STO=%0d D=%h required STO=%0d D=%h",
                         i, obs_q[i].slot, obs_q[i].data, exp_q[i].slot, exp_q[i].data);
            end
        end
        checks++;
        if (zero_viol != 0) begin
            failures++;
            $display("FAIL idle_zero: %0d cycles with STO/D nonzero while Enable=0, required 0", zero_viol);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_ring_snooze();
        test_priority();
        test_snooze_wrap();
        test_arbitration();
        test_clear_mid_scan();
        test_bank_writes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
